// File: rtl/jesd204b_rx_link_ctrl_if.sv
// -----------------------------------------------------------------------------
// jesd204b_rx_link_ctrl_if
// Bundles the link-control signals of jesd204b_rx_link_ctrl.
//   master : the side that drives link enable, SYSREF and per-lane status
//   slave  : the link controller; returns LMFC, SYNC~ and link status
// Signals:
//   enable, sysref               link enable, SYSREF (synchronous to clk)
//   lane_enable/_sync_request/_valid  per-lane status, NUM_LANES wide
//   lmfc, sync_n                 LMFC pulse, active-low SYNC~
//   link_state, link_up          0 IDLE / 1 CGS / 2 ILAS / 3 DATA, high in DATA
//   sysref_locked, resync_count  SYSREF seen since reset, saturating drop count
// -----------------------------------------------------------------------------
interface jesd204b_rx_link_ctrl_if #(
    parameter int NUM_LANES = 4
);
    logic                 enable;
    logic                 sysref;
    logic [NUM_LANES-1:0] lane_enable;
    logic [NUM_LANES-1:0] lane_sync_request;
    logic [NUM_LANES-1:0] lane_valid;
    logic                 lmfc;
    logic                 sync_n;
    logic [1:0]           link_state;
    logic                 link_up;
    logic                 sysref_locked;
    logic [7:0]           resync_count;

    modport master (
        output enable, sysref, lane_enable, lane_sync_request, lane_valid,
        input  lmfc, sync_n, link_state, link_up, sysref_locked, resync_count
    );

    modport slave (
        input  enable, sysref, lane_enable, lane_sync_request, lane_valid,
        output lmfc, sync_n, link_state, link_up, sysref_locked, resync_count
    );
endinterface

// File: rtl/jesd204b_rx_link_ctrl.sv
// -----------------------------------------------------------------------------
// jesd204b_rx_link_ctrl
// Link-level controller for a multi-lane JESD204B receiver. Generates the
// SYSREF-aligned LMFC, merges per-lane sync requests into SYNC~, and sequences
// the link IDLE -> CGS -> ILAS -> DATA, falling back to CGS on lane sync
// requests, loss of all lanes, or too many invalid characters per multiframe.
// Ports:
//   clk    device clock
//   reset  synchronous, active-high
//   link   jesd204b_rx_link_ctrl_if.slave (see interface header)
// -----------------------------------------------------------------------------
module jesd204b_rx_link_ctrl #(
    parameter int NUM_LANES      = 4,
    parameter int OCTET_PER_SENT = 4,
    parameter int OCTETS_PER_FR  = 5,
    parameter int FRAMES_PER_MF  = 4,
    parameter int ILAS_MF        = 4,
    parameter int ERR_THRESH     = 3,
    parameter bit REQUIRE_SYSREF = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    jesd204b_rx_link_ctrl_if.slave   link
);
    localparam int P  = (OCTETS_PER_FR * FRAMES_PER_MF) / OCTET_PER_SENT;
    localparam int CW = (P > 1) ? $clog2(P) : 1;
    localparam int MW = $clog2(ILAS_MF + 1);
    localparam int EW = $clog2(ERR_THRESH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CGS  = 2'd1,
        ST_ILAS = 2'd2,
        ST_DATA = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [MW-1:0]  mf_cnt_q, mf_cnt_d;
    logic [EW-1:0]  err_cnt_q, err_cnt_d;
    logic [7:0]     resync_q, resync_d;
    logic           lmfc_q, lmfc_d;
    logic           sync_n_q, sync_n_d;
    logic           link_up_q, link_up_d;
    logic           locked_q, locked_d;

    logic [NUM_LANES-1:0] act;
    logic                 any_req, all_sync, bad, resync;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        act      = link.lane_enable;
        any_req  = |(link.lane_sync_request & act);
        all_sync = (act != '0) && !any_req;
        bad      = |(~link.lane_valid & act);

        // LMFC: SYSREF restarts the multiframe immediately.
        if (link.sysref || cnt_q == CW'(P - 1)) begin
            cnt_d  = '0;
            lmfc_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + 1'b1;
            lmfc_d = 1'b0;
        end
        locked_d = locked_q | link.sysref;

        state_d   = state_q;
        mf_cnt_d  = mf_cnt_q;
        err_cnt_d = '0;
        resync_d  = resync_q;

        case (state_q)
            ST_IDLE: state_d = ST_CGS;
            ST_CGS: begin
                mf_cnt_d = '0;
                if (all_sync && lmfc_q && (locked_q || !REQUIRE_SYSREF))
                    state_d = ST_ILAS;
            end
            ST_ILAS: begin
                if (lmfc_q) begin
                    mf_cnt_d = mf_cnt_q + 1'b1;
                    if (mf_cnt_q + 1'b1 == MW'(ILAS_MF))
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // Errors are counted per multiframe; a bad LMFC cycle opens
                // the new window with one error already recorded.
                if (lmfc_q)
                    err_cnt_d = bad ? EW'(1) : '0;
                else if (bad && err_cnt_q != EW'(ERR_THRESH))
                    err_cnt_d = err_cnt_q + 1'b1;
                else
                    err_cnt_d = err_cnt_q;
            end
            default: state_d = ST_IDLE;
        endcase

        // Losing every lane is treated like an explicit sync request.
        resync = (state_q == ST_ILAS || state_q == ST_DATA) &&
                 (any_req || act == '0 || err_cnt_q == EW'(ERR_THRESH));
        if (resync) begin
            state_d   = ST_CGS;
            mf_cnt_d  = '0;
            err_cnt_d = '0;
            if (resync_q != 8'hFF)
                resync_d = resync_q + 8'd1;
        end

        // Disabling the link overrides a resync and is not counted as one.
        if (!link.enable) begin
            state_d   = ST_IDLE;
            mf_cnt_d  = '0;
            err_cnt_d = '0;
            resync_d  = resync_q;
        end

        // SYNC~ and link_up follow the next state so they change with it.
        sync_n_d  = (state_d == ST_ILAS) || (state_d == ST_DATA);
        link_up_d = (state_d == ST_DATA);
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values; reset is synchronous, checked inside the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mf_cnt_q  <= '0;
            err_cnt_q <= '0;
            resync_q  <= '0;
            lmfc_q    <= 1'b0;
            sync_n_q  <= 1'b0;
            link_up_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mf_cnt_q  <= mf_cnt_d;
            err_cnt_q <= err_cnt_d;
            resync_q  <= resync_d;
            lmfc_q    <= lmfc_d;
            sync_n_q  <= sync_n_d;
            link_up_q <= link_up_d;
            locked_q  <= locked_d;
        end
    end

    assign link.lmfc          = lmfc_q;
    assign link.sync_n        = sync_n_q;
    assign link.link_state    = state_q;
    assign link.link_up       = link_up_q;
    assign link.sysref_locked = locked_q;
    assign link.resync_count  = resync_q;
endmodule

// File: tb/tb_jesd204b_rx_link_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jesd204b_rx_link_ctrl
// Directed bench for jesd204b_rx_link_ctrl. A cycle-level model derives the
// expected outputs from the link rules (LMFC as cycles since last alignment,
// drop count as an unbounded integer clipped to 8 bits); the outputs are
// compared against it on every falling edge, and literal expectations at key
// points pin the model itself.
// -----------------------------------------------------------------------------
module tb_jesd204b_rx_link_ctrl;
    localparam int NL         = 4;
    localparam int P          = 5;
    localparam int ILAS_MF    = 4;
    localparam int ERR_THRESH = 3;
    localparam bit REQ_SYSREF = 1'b1;

    logic clk;
    logic reset;

    jesd204b_rx_link_ctrl_if #(.NUM_LANES(NL)) vif ();

    jesd204b_rx_link_ctrl #(
        .NUM_LANES(NL), .OCTET_PER_SENT(4), .OCTETS_PER_FR(5), .FRAMES_PER_MF(4),
        .ILAS_MF(ILAS_MF), .ERR_THRESH(ERR_THRESH), .REQUIRE_SYSREF(REQ_SYSREF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .link  (vif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int cyc, anchor, m_state, m_mf, m_bad, m_drops;
    bit m_lmfc, m_locked, model_on = 1'b0;

    always @(posedge clk) begin : model
        bit          n_lmfc, any_req, all_sync, bad, resync;
        int          n_state, n_mf, n_bad;
        logic [NL-1:0] act;
        if (reset) begin
            cyc = 0; anchor = 0; m_state = 0; m_mf = 0; m_bad = 0; m_drops = 0;
            m_lmfc = 1'b0; m_locked = 1'b0; model_on = 1'b1;
        end else begin
            cyc++;
            act      = vif.lane_enable;
            any_req  = (vif.lane_sync_request & act) != '0;
            all_sync = (act != '0) && !any_req;
            bad      = (~vif.lane_valid & act) != '0;
            n_lmfc   = vif.sysref || (cyc - anchor == P);
            if (n_lmfc) anchor = cyc;

            n_state = m_state; n_mf = m_mf; n_bad = 0;
            resync  = (m_state >= 2) && (any_req || act == '0 || m_bad >= ERR_THRESH);
            if (!vif.enable) begin
                n_state = 0; n_mf = 0;
            end else if (resync) begin
                n_state = 1; n_mf = 0; m_drops++;
            end else begin
                case (m_state)
                    0: n_state = 1;
                    1: begin
                        n_mf = 0;
                        if (all_sync && m_lmfc && (m_locked || !REQ_SYSREF)) n_state = 2;
                    end
                    2: if (m_lmfc) begin
                        n_mf = m_mf + 1;
                        if (n_mf == ILAS_MF) n_state = 3;
                    end
                    default: begin
                        n_bad = m_lmfc ? int'(bad) : m_bad + int'(bad);
                        if (n_bad > ERR_THRESH) n_bad = ERR_THRESH;
                    end
                endcase
            end
            m_locked = m_locked || vif.sysref;
            m_lmfc   = n_lmfc;
            m_state  = n_state;
            m_mf     = n_mf;
            m_bad    = n_bad;
        end
    end

    function automatic logic [13:0] model_vec();
        logic [7:0] rc;
        logic [1:0] st;
        rc = (m_drops > 255) ? 8'd255 : 8'(m_drops);
        st = 2'(m_state);
        return {m_lmfc, m_state >= 2, st, m_state == 3, m_locked, rc};
    endfunction

    always @(negedge clk) begin
        if (model_on)
            check("outputs", {18'd0, vif.lmfc, vif.sync_n, vif.link_state, vif.link_up,
                              vif.sysref_locked, vif.resync_count}, {18'd0, model_vec()});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input int st, input int budget);
        int n = 0;
        while (vif.link_state != 2'(st) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_state", vif.link_state, st);
    endtask

    task automatic wait_lmfc(input int budget);
        int n = 0;
        while (vif.lmfc !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_lmfc", vif.lmfc, 1);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        vif.enable = 1'b0; vif.sysref = 1'b0;
        vif.lane_enable = '0; vif.lane_sync_request = '0; vif.lane_valid = '1;
        step(3);
        check("reset_state", {vif.lmfc, vif.sync_n, vif.link_state, vif.link_up, vif.sysref_locked}, 0);
        check("reset_count", vif.resync_count, 0);

        // Test 1: SYSREF at edge 2, bring-up to DATA.
        reset = 1'b0; vif.enable = 1'b1; vif.lane_enable = 4'hF;
        step(1);
        vif.sysref = 1'b1;
        step(1);                               // after edge 2
        vif.sysref = 1'b0;
        check("t1_lmfc_e2", vif.lmfc, 1);
        check("t1_cgs_e2", vif.link_state, 1);
        check("t1_syncn_e2", vif.sync_n, 0);
        step(1);                               // after edge 3
        check("t1_ilas_e3", vif.link_state, 2);
        check("t1_syncn_e3", vif.sync_n, 1);
        step(19);                              // after edge 22: 4th ILAS pulse
        check("t1_ilas_e22", {vif.link_state, vif.lmfc}, {2'd2, 1'b1});
        step(1);                               // after edge 23
        check("t1_data_e23", {vif.link_state, vif.link_up}, {2'd3, 1'b1});

        // Test 3: lane sync request, then masked request.
        vif.lane_sync_request = 4'b0100;
        step(1);
        vif.lane_sync_request = '0;
        check("t3_req_cgs", {vif.link_state, vif.sync_n}, {2'd1, 1'b0});
        check("t3_req_count", vif.resync_count, 1);
        wait_state(3, 100);
        vif.lane_enable = 4'b1011; vif.lane_sync_request = 4'b0100;
        step(1);
        vif.lane_sync_request = '0; vif.lane_enable = 4'hF;
        step(1);
        check("t3_masked", {vif.link_state, vif.resync_count}, {2'd3, 8'd1});

        // Test 4: three bad cycles in one multiframe -> resync.
        wait_lmfc(20);
        step(1);
        vif.lane_valid = 4'hE;
        step(3);
        vif.lane_valid = 4'hF;
        step(1);
        check("t4_err_resync", {vif.link_state, vif.resync_count}, {2'd1, 8'd2});
        // Two bad, LMFC, two bad -> no resync.
        wait_state(3, 100);
        wait_lmfc(20);
        step(3);
        vif.lane_valid = 4'hE;
        step(2);
        vif.lane_valid = 4'hF;
        step(1);
        vif.lane_valid = 4'hE;
        step(2);
        vif.lane_valid = 4'hF;
        step(3);
        check("t4_split_err", {vif.link_state, vif.resync_count}, {2'd3, 8'd2});

        // Test 5: enable drop mid-ILAS, lane loss, reset mid-DATA.
        vif.lane_sync_request = 4'b0001;
        step(1);
        vif.lane_sync_request = '0;
        wait_state(2, 50);
        step(3);
        vif.enable = 1'b0;
        step(1);
        check("t5_idle", {vif.link_state, vif.sync_n, vif.resync_count}, {2'd0, 1'b0, 8'd3});
        vif.enable = 1'b1;
        wait_state(3, 100);
        vif.lane_enable = '0;
        step(1);
        vif.lane_enable = 4'hF;
        check("t5_lane_loss", {vif.link_state, vif.resync_count}, {2'd1, 8'd4});
        wait_state(3, 100);
        reset = 1'b1;
        step(1);
        check("t5_reset", {vif.lmfc, vif.sync_n, vif.link_state, vif.link_up,
                           vif.sysref_locked, vif.resync_count}, 0);

        // Test 2: no SYSREF -> CGS holds; SYSREF at edge 40 -> ILAS at edge 41.
        reset = 1'b0;
        step(39);
        check("t2_hold_cgs", {vif.link_state, vif.sync_n, vif.sysref_locked}, {2'd1, 1'b0, 1'b0});
        vif.sysref = 1'b1;
        step(1);
        vif.sysref = 1'b0;
        check("t2_e40", {vif.link_state, vif.lmfc, vif.sysref_locked}, {2'd1, 1'b1, 1'b1});
        step(1);
        check("t2_e41", {vif.link_state, vif.sync_n}, {2'd2, 1'b1});

        // Test 6: 300 resyncs -> saturation at 255.
        for (int i = 0; i < 300; i++) begin
            wait_state(2, 50);
            vif.lane_sync_request = 4'b0001;
            step(1);
            vif.lane_sync_request = '0;
        end
        step(1);
        check("t6_saturate", vif.resync_count, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jesd204b_rx_link_ctrl.md
# jesd204b_rx_link_ctrl

Link-level controller for a multi-lane JESD204B receiver. It generates the local multiframe clock (LMFC), aligned by SYSREF, and combines the per-lane `sync_request` flags into one active-low SYNC~ line. It sequences the link through CGS, ILAS and DATA, and forces re-synchronisation on lane loss or excessive invalid characters. It sits above the per-lane data-link RX instances: it feeds them `lmfc` and consumes their `sync_request` outputs.

## Interface
- `NUM_LANES`, 4, number of lanes supervised (1..8)
- `OCTET_PER_SENT`, 4, octets per lane per clock
- `OCTETS_PER_FR`, 5, F
- `FRAMES_PER_MF`, 4, K
  - `OCTETS_PER_FR*FRAMES_PER_MF` must be divisible by `OCTET_PER_SENT`.
  - LMFC period `P` = F*K/`OCTET_PER_SENT` clocks (default 5).
- `ILAS_MF`, 4, multiframes spent in ILAS before DATA
- `ERR_THRESH`, 3, invalid-cycle count within one multiframe that forces resync
- `REQUIRE_SYSREF`, 1, when 1, CGS cannot exit before the first SYSREF is seen
---
- `clk` in 1 — device clock; the single clock
- `reset` in 1 — synchronous, active-high
- `enable` in 1 — link enable; low forces IDLE
- `sysref` in 1 — SYSREF, already synchronous to `clk`; single-cycle pulse or level (every high cycle is treated as an event)
- `lane_enable` in NUM_LANES — lanes in use; disabled lanes are ignored
- `lane_sync_request` in NUM_LANES — per-lane sync request from the DL RX
- `lane_valid` in NUM_LANES — per-lane character-valid flag
- `lmfc` out 1 — one-cycle LMFC pulse
- `sync_n` out 1 — SYNC~ to the transmitter, active low
- `link_state` out 2 — 0 IDLE, 1 CGS, 2 ILAS, 3 DATA
- `link_up` out 1 — high only in DATA
- `sysref_locked` out 1 — a SYSREF has been seen since reset
- `resync_count` out 8 — saturating count of DATA/ILAS→CGS drops

## Operation
- **LMFC counter** `cnt` runs 0..P-1. Each clock:
  - if `sysref` or `cnt==P-1`: `cnt<=0`, `lmfc<=1`
  - else: `cnt<=cnt+1`, `lmfc<=0`
  - `sysref` high sets `sysref_locked<=1`, which stays set until reset.
- **Signal definitions**
  - `act` = `lane_enable`.
  - `all_sync` = (`act`≠0) and no bit of (`lane_sync_request & act`) set.
  - `any_req` = any bit of (`lane_sync_request & act`) set.
  - `bad` = any bit of (~`lane_valid & act`) set.
- **IDLE**: `sync_n=0`. Goes to CGS when `enable`=1.
- **CGS**: `sync_n=0`, ILAS counter cleared, error counter cleared.
  - Exit to ILAS when `all_sync` and `lmfc` are high in the same cycle, and (`sysref_locked` or `REQUIRE_SYSREF`=0).
  - `sync_n` rises together with the state change.
- **ILAS**: `sync_n=1`. Each `lmfc` pulse increments `mf_cnt`.
  - The pulse that makes `mf_cnt==ILAS_MF` moves the block to DATA.
- **DATA**: `sync_n=1`, `link_up=1`.
  - `err_cnt` (saturating at `ERR_THRESH`) increments on each `bad` cycle.
  - `err_cnt` clears on `lmfc`; if `bad` is also high that cycle, it restarts at 1.
- **Resync**: in ILAS or DATA, `any_req`, or `err_cnt` reaching `ERR_THRESH`, causes:
  - next state CGS
  - `sync_n<=0`
  - `resync_count` incremented, saturating at 255
- **Priority**, highest first: `reset` > `enable`=0 (IDLE, no count change) > resync > normal transition.
- Clearing `lane_enable` to all zeros while in ILAS or DATA counts as a resync (`all_sync` false, `any_req` false). This is handled by an explicit rule: `act==0` in ILAS/DATA triggers a resync.
- SYSREF arriving mid-ILAS/DATA realigns LMFC only. The state machine is not reset, and `mf_cnt` counts the resulting pulses normally.

## Timing
- **Reset values**: `lmfc=0`, `sync_n=0`, `link_state=0`, `link_up=0`, `sysref_locked=0`, `resync_count=0`. Internal `cnt=0`, `mf_cnt=0`, `err_cnt=0`.
- All outputs are registered; every transition takes effect at the clock edge after its condition is sampled.
- With no SYSREF, `lmfc` first pulses at cycle P after reset release (cycle 5 for default parameters), then every P cycles.
- SYSREF sampled at edge t gives `lmfc` high in cycle t+1, and the next pulse at t+1+P.
- CGS→ILAS exits only on an `lmfc` cycle. ILAS therefore lasts exactly `ILAS_MF*P` cycles (default 20).

## Test plan
1. Reset, then `sysref` at edge 2, `enable`=1, `lane_enable`=4'hF, all `lane_sync_request`=0 → `lmfc` at 3, 8, 13…; ILAS from 3; DATA (`link_state`=3, `link_up`=1) after the 4th ILAS `lmfc` pulse; `sync_n` low until edge 3.
2. `REQUIRE_SYSREF`=1, no `sysref`, all lanes synced → stays in CGS with `sync_n`=0; a `sysref` at edge 40 → ILAS at edge 41.
3. In DATA, pulse `lane_sync_request[2]`=1 for one cycle → CGS and `sync_n`=0 next cycle, `resync_count`=1; bit 2 with `lane_enable[2]`=0 → no effect.
4. In DATA, drive `lane_valid[0]`=0 for 3 cycles inside one multiframe → resync. Drive 2 bad cycles, then `lmfc`, then 2 more → no resync.
5. Drop `enable` mid-ILAS → IDLE next cycle, `resync_count` unchanged. Assert `reset` mid-DATA → all outputs at their reset values next cycle.
6. Force 300 resyncs → `resync_count` saturates at 255.
